// File: rtl/freq_div_ctrl.sv
// Round-robin arbitrated ratio controller for freq_div_and_switch: grants one requester,
// applies its ratio, then holds off for a settle window. Optional switch counter: FREQ_DIV_CTRL_SWCNT_EN.
module freq_div_ctrl #(
  parameter int NREQ           = 4,
  parameter int DW             = 8,
  parameter int SETTLE_PERIODS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_div,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        div,
  output logic                 busy,
  output logic [2:0]           owner
`ifdef FREQ_DIV_CTRL_SWCNT_EN
  ,
  output logic [15:0]          sw_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = DW + 4;

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   nxt_q, nxt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   settle_len;

  logic [PW-1:0]   grant_idx;
  logic            grant_found;
  logic [NREQ-1:0] grant_oh;
  logic            accept;
  logic            changed;

  logic [DW-1:0]   div_arr    [NREQ];
  logic [PW-1:0]   cand_idx   [NREQ];
  logic [NREQ-1:0] cand_valid;

  // Candidate k is the requester k places after rr_ptr, wrapping at NREQ.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [PW:0] sum;
    assign div_arr[gi]    = req_div[gi*DW +: DW];
    assign sum            = {1'b0, rr_ptr_q} + (PW+1)'(gi);
    assign cand_idx[gi]   = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
    assign cand_valid[gi] = req_valid[cand_idx[gi]];
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && cand_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant_found) grant_oh[grant_idx] = 1'b1;
  end

  assign accept     = |(req_valid & req_ready);
  assign changed    = (nxt_q != div_q);
  // Settle window length: whole output periods of the new ratio (period = 2*nxt+2 cycles).
  assign settle_len = CW'(SETTLE_PERIODS) * ((CW'(nxt_q) << 1) + CW'(2));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      nxt_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      nxt_q    <= nxt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = changed ? SETTLE : IDLE;
      SETTLE:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d    = div_q;
    nxt_d    = nxt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          nxt_d    = div_arr[grant_idx];
          owner_d  = 3'(grant_idx);
          rr_ptr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
        end
      end
      APPLY: begin
        div_d = nxt_q;
        if (changed) cnt_d = settle_len - CW'(1);
      end
      SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  // Output logic; ready is suppressed during the reset cycle.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) req_ready = grant_oh;
  end

  assign busy  = (state_q != IDLE);
  assign div   = div_q;
  assign owner = owner_q;

`ifdef FREQ_DIV_CTRL_SWCNT_EN
  logic [15:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if (state_q == APPLY && changed && sw_cnt_q != 16'hFFFF) sw_cnt_d = sw_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) sw_cnt_q <= '0;
    else     sw_cnt_q <= sw_cnt_d;
  end

  assign sw_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed testbench for freq_div_ctrl at NREQ=4, DW=8, SETTLE_PERIODS=2.
// Also checks sw_cnt when FREQ_DIV_CTRL_SWCNT_EN is defined.
module tb_freq_div_ctrl;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SP   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_div;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        div;
  logic                 busy;
  logic [2:0]           owner;
`ifdef FREQ_DIV_CTRL_SWCNT_EN
  logic [15:0]          sw_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  freq_div_ctrl #(.NREQ(NREQ), .DW(DW), .SETTLE_PERIODS(SP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_div   (req_div),
    .req_ready (req_ready),
    .div       (div),
    .busy      (busy),
    .owner     (owner)
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    ,
    .sw_cnt    (sw_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_div(input int i, input logic [DW-1:0] v);
    req_div[i*DW +: DW] = v;
  endtask

  // Counts sampled cycles with busy high; bounded so a stuck DUT still ends.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 5000) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_div   = '0;

    // 1. Reset
    repeat (3) step();
    chk("rst_ready_during", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    chk("rst_div", {24'd0, div}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {29'd0, owner}, 32'd0);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("rst_swcnt", {16'd0, sw_cnt}, 32'd0);
`endif

    // 2. Single request from requester 1, div=5
    set_div(1, 8'd5);
    req_valid = 4'b0010;
    #1;
    chk("t2_ready", {28'd0, req_ready}, 32'b0010);
    step();
    req_valid = '0;
    chk("t2_apply_busy", {31'd0, busy}, 32'd1);
    chk("t2_owner", {29'd0, owner}, 32'd1);
    chk("t2_div_before_apply", {24'd0, div}, 32'd0);
    chk("t2_ready_apply", {28'd0, req_ready}, 32'd0);
    step();
    chk("t2_div", {24'd0, div}, 32'd5);
    count_busy(n);
    chk("t2_settle_len", n, 32'd24);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t2_swcnt", {16'd0, sw_cnt}, 32'd1);
`endif

    // 3. No-op request from requester 2 with the current ratio
    set_div(2, 8'd5);
    req_valid = 4'b0100;
    #1;
    chk("t3_ready", {28'd0, req_ready}, 32'b0100);
    step();
    req_valid = '0;
    chk("t3_busy_apply", {31'd0, busy}, 32'd1);
    chk("t3_owner", {29'd0, owner}, 32'd2);
    step();
    chk("t3_busy_done", {31'd0, busy}, 32'd0);
    chk("t3_div", {24'd0, div}, 32'd5);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t3_swcnt", {16'd0, sw_cnt}, 32'd1);
`endif

    // Reset so contention starts from rr_ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_pre_div", {24'd0, div}, 32'd0);

    // 4. Contention: all four valid with ratios 1,2,3,4
    for (int i = 0; i < NREQ; i++) set_div(i, 8'(i + 1));
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      #1;
      chk($sformatf("t4_ready_%0d", i), {28'd0, req_ready}, 32'(1 << i));
      step();
      req_valid[i] = 1'b0;
      chk($sformatf("t4_owner_%0d", i), {29'd0, owner}, 32'(i));
      step();
      chk($sformatf("t4_div_%0d", i), {24'd0, div}, 32'(i + 1));
      chk($sformatf("t4_ready_busy_%0d", i), {28'd0, req_ready}, 32'd0);
      count_busy(n);
      chk($sformatf("t4_settle_%0d", i), n, 32'(4 * i + 8));
    end
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t4_swcnt", {16'd0, sw_cnt}, 32'd4);
`endif

    // 5. Requests arriving during SETTLE, one dropped, one changing its ratio
    set_div(0, 8'd6);
    req_valid = 4'b0001;
    #1;
    chk("t5_ready0", {28'd0, req_ready}, 32'b0001);
    step();
    req_valid = '0;
    step();
    chk("t5_div6", {24'd0, div}, 32'd6);
    repeat (5) step();
    set_div(3, 8'd8);
    set_div(2, 8'd9);
    req_valid = 4'b1100;
    #1;
    chk("t5_ready_settle_a", {28'd0, req_ready}, 32'd0);
    step();
    step();
    req_valid = 4'b1000;
    set_div(3, 8'd7);
    #1;
    chk("t5_ready_settle_b", {28'd0, req_ready}, 32'd0);
    count_busy(n);
    chk("t5_remaining", n, 32'd21);
    #1;
    chk("t5_ready_idle", {28'd0, req_ready}, 32'b1000);
    step();
    req_valid = '0;
    chk("t5_owner", {29'd0, owner}, 32'd3);
    step();
    chk("t5_div7", {24'd0, div}, 32'd7);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t5_swcnt", {16'd0, sw_cnt}, 32'd6);
`endif
    count_busy(n);
    chk("t5_settle7", n, 32'd32);

    // 6. Reset mid-SETTLE (div=5, cnt=10) with requesters 0 and 3 pending
    set_div(1, 8'd5);
    req_valid = 4'b0010;
    #1;
    chk("t6_ready1", {28'd0, req_ready}, 32'b0010);
    step();
    req_valid = '0;
    chk("t6_owner1", {29'd0, owner}, 32'd1);
    step();
    chk("t6_div5", {24'd0, div}, 32'd5);
    repeat (13) step();
    set_div(0, 8'd3);
    set_div(3, 8'd9);
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    chk("t6_ready_in_rst", {28'd0, req_ready}, 32'd0);
    step();
    rst = 1'b0;
    chk("t6_div_rst", {24'd0, div}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    chk("t6_owner_rst", {29'd0, owner}, 32'd0);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t6_swcnt_rst", {16'd0, sw_cnt}, 32'd0);
`endif
    #1;
    chk("t6_ready_after", {28'd0, req_ready}, 32'b0001);
    step();
    req_valid = 4'b1000;
    chk("t6_owner0", {29'd0, owner}, 32'd0);
    step();
    chk("t6_div3", {24'd0, div}, 32'd3);
    count_busy(n);
    chk("t6_settle3", n, 32'd16);
    #1;
    chk("t6_ready3", {28'd0, req_ready}, 32'b1000);
    step();
    req_valid = '0;
    chk("t6_owner3", {29'd0, owner}, 32'd3);
    step();
    chk("t6_div9", {24'd0, div}, 32'd9);
`ifdef FREQ_DIV_CTRL_SWCNT_EN
    chk("t6_swcnt", {16'd0, sw_cnt}, 32'd2);
`endif
    count_busy(n);
    chk("t6_settle9", n, 32'd40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
